pulse_gen_multi: RTL
====================

PULSE_GEN_MULTI -- requirements
Module: pulse_gen_multi

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of independent pulse channels (1..16).
REQ-002 SHALL have parameter CW, default 32, meaning counter and configuration width in bits.
REQ-003 SHALL have parameter DEF_PER, default 400000, meaning reset value of every channel's period register.
REQ-004 SHALL have parameter DEF_DLY, default 200000, meaning reset value of every channel's delay register.
REQ-005 SHALL have parameter DEF_WID, default 200001, meaning reset value of every channel's width register.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port en  input  1  global enable; low forces all channels to IDLE.
REQ-009 SHALL have port trig  input  NCH  per-channel start strobe, one bit per channel.
REQ-010 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-011 SHALL have port cfg_ch  input  4  target channel of write; values >= NCH ignored.
REQ-012 SHALL have port cfg_sel  input  2  target register: 0 period, 1 delay, 2 width, 3 mode.
REQ-013 SHALL have port cfg_data  input  CW  write data; mode uses bits [1:0] (bit0 one-shot, bit1 invert).
REQ-014 SHALL have port pulse_out  output  NCH  per-channel pulse output.
REQ-015 SHALL have port busy  output  NCH  per-channel high while in RUN.
REQ-016 SHALL have port done  output  NCH  per-channel one-cycle strobe on one-shot completion.

Function
REQ-017 Each channel SHALL hold shadow registers (PER, DLY, WID, MODE) written by cfg_we and active copies used by the counter.
REQ-018 Each channel SHALL implement states IDLE, RUN, HOLD.
REQ-019 IDLE->RUN when en=1 and trig[i]=1; counter set to 0 and active registers loaded from shadow in that cycle.
REQ-020 In RUN the counter SHALL increment by 1 per cycle, wrapping to 0 on the cycle after count==PER (cycle length PER+1; PER=0 keeps count at 0).
REQ-021 At wrap, active registers SHALL load shadow values as they stood before any same-cycle write (a write coinciding with wrap takes effect at the next wrap).
REQ-022 At wrap with active MODE bit0=1, channel SHALL go RUN->HOLD instead of restarting, and done[i] SHALL pulse for exactly one cycle.
REQ-023 HOLD->RUN on trig[i]=1 with en=1, identical to IDLE start; trig in RUN SHALL be ignored.
REQ-024 Raw level SHALL be 1 iff state is RUN and count>=DLY and (count-DLY)<WID, computed without overflow; WID=0 yields never high.
REQ-025 pulse_out[i] SHALL be registered: raw level XOR active MODE bit1, one cycle after the count value producing it.
REQ-026 Outside RUN, pulse_out[i] SHALL equal active MODE bit1 (idle level).
REQ-027 en=0 SHALL move every channel to IDLE on the next edge, clearing counters; shadow registers are retained.
REQ-028 Simultaneous en falling and wrap SHALL resolve to IDLE with no done strobe.
REQ-029 Writes SHALL be accepted in every state, including during en=0; writes to cfg_ch>=NCH SHALL have no effect.

Reset
REQ-030 While resetn=0 all channels SHALL be IDLE, counters 0, pulse_out=0, busy=0, done=0.
REQ-031 Reset SHALL load shadow and active PER/DLY/WID with DEF_PER/DEF_DLY/DEF_WID and MODE with 0.
REQ-032 Reset asserted mid-RUN SHALL take effect immediately without waiting for a clock edge.

Verification
REQ-033 Defaults, en=1, trig[0] pulse -> pulse_out[0] low 200000 cycles then high 200001 cycles, period 400001, repeating.
REQ-034 Ch1 PER=9, DLY=2, WID=3, MODE=1, trig -> pulse_out[1] high for counts 2..4 only, done[1] one cycle after count 9, busy drops, state HOLD.
REQ-035 Ch2 running PER=9; write PER=4 mid-period -> current period 10 cycles, following periods 5 cycles; write on wrap cycle applies one period later.
REQ-036 Ch3 MODE=2 (invert), DLY=0, WID=0 -> pulse_out[3] constantly 1 in IDLE and RUN.
REQ-037 en dropped mid-RUN on all channels -> next cycle busy=0, pulse_out at idle level; re-trig restarts from count 0.
REQ-038 resetn pulsed low between edges during RUN -> outputs 0 immediately, defaults restored, no done strobe.

Source files
------------

// File: rtl/pulse_gen_multi.sv
// rtl/pulse_gen_multi.sv - multi-channel programmable delayed pulse generator
module pulse_gen_multi #(
  parameter int NCH     = 4,
  parameter int CW      = 32,
  parameter int DEF_PER = 400000,
  parameter int DEF_DLY = 200000,
  parameter int DEF_WID = 200001
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [NCH-1:0]    trig,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [CW-1:0]     cfg_data,
  output logic [NCH-1:0]    pulse_out,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] per_sh_q, per_sh_d;
    logic [CW-1:0] dly_sh_q, dly_sh_d;
    logic [CW-1:0] wid_sh_q, wid_sh_d;
    logic [1:0]    mode_sh_q, mode_sh_d;
    logic [CW-1:0] per_act_q, per_act_d;
    logic [CW-1:0] dly_act_q, dly_act_d;
    logic [CW-1:0] wid_act_q, wid_act_d;
    logic [1:0]    mode_act_q, mode_act_d;
    logic          pulse_q, pulse_d;
    logic          done_q, done_d;
    logic          wr_hit;
    logic          load_act;
    logic          in_win;

    // Shadow register writes; accepted in any state, only for this channel's index
    always_comb begin
      wr_hit    = cfg_we && (cfg_ch == 4'(i));
      per_sh_d  = per_sh_q;
      dly_sh_d  = dly_sh_q;
      wid_sh_d  = wid_sh_q;
      mode_sh_d = mode_sh_q;
      if (wr_hit) begin
        case (cfg_sel)
          2'd0:    per_sh_d  = cfg_data;
          2'd1:    dly_sh_d  = cfg_data;
          2'd2:    wid_sh_d  = cfg_data;
          default: mode_sh_d = cfg_data[1:0];
        endcase
      end
    end

    // Channel FSM, period counter, active-register reload and registered pulse level
    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      per_act_d  = per_act_q;
      dly_act_d  = dly_act_q;
      wid_act_d  = wid_act_q;
      mode_act_d = mode_act_q;
      done_d     = 1'b0;
      load_act   = 1'b0;
      // Subtraction only happens once count >= DLY, so no wrap-around is possible
      in_win     = (cnt_q >= dly_act_q) && ((cnt_q - dly_act_q) < wid_act_q);
      pulse_d    = mode_act_q[1];
      if (!en) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE, ST_HOLD: begin
            if (trig[i]) begin
              state_d  = ST_RUN;
              cnt_d    = '0;
              load_act = 1'b1;
            end
          end
          ST_RUN: begin
            pulse_d = in_win ^ mode_act_q[1];
            if (cnt_q == per_act_q) begin
              cnt_d    = '0;
              load_act = 1'b1;
              if (mode_act_q[0]) begin
                state_d = ST_HOLD;
                done_d  = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
      // Shadow values read here are pre-write, so a same-cycle write waits a period
      if (load_act) begin
        per_act_d  = per_sh_q;
        dly_act_d  = dly_sh_q;
        wid_act_d  = wid_sh_q;
        mode_act_d = mode_sh_q;
      end
    end

    // State and configuration registers with asynchronous reset to defaults
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        per_sh_q   <= CW'(DEF_PER);
        dly_sh_q   <= CW'(DEF_DLY);
        wid_sh_q   <= CW'(DEF_WID);
        mode_sh_q  <= 2'b00;
        per_act_q  <= CW'(DEF_PER);
        dly_act_q  <= CW'(DEF_DLY);
        wid_act_q  <= CW'(DEF_WID);
        mode_act_q <= 2'b00;
        pulse_q    <= 1'b0;
        done_q     <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        per_sh_q   <= per_sh_d;
        dly_sh_q   <= dly_sh_d;
        wid_sh_q   <= wid_sh_d;
        mode_sh_q  <= mode_sh_d;
        per_act_q  <= per_act_d;
        dly_act_q  <= dly_act_d;
        wid_act_q  <= wid_act_d;
        mode_act_q <= mode_act_d;
        pulse_q    <= pulse_d;
        done_q     <= done_d;
      end
    end

    assign pulse_out[i] = pulse_q;
    assign busy[i]      = (state_q == ST_RUN);
    assign done[i]      = done_q;
  end

endmodule
